// File: rtl/fetch_pkg.sv
// Shared constants, FSM state encoding and slot layout for the instruction-fetch front end.
package fetch_pkg;

  localparam logic [4:0]  CAUSE_INST_MISALIGNED   = 5'd0;
  localparam logic [4:0]  CAUSE_INST_ACCESS_FAULT = 5'd1;
  localparam logic [4:0]  CAUSE_NONE              = 5'd31;
  localparam logic [31:0] INST_NOP                = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [4:0]  cause;
    logic [63:0] tval;
  } slot_t;

endpackage

// File: rtl/fetch_obuf.sv
// Single-entry output slot feeding IF/ID; presents NOP/CAUSE_NONE when empty.
// Clear beats load beats pop.
module fetch_obuf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        pop_i,
  input  logic        clear_i,
  input  logic [31:0] inst_i,
  input  logic [63:0] pc_i,
  input  logic [4:0]  cause_i,
  input  logic [63:0] tval_i,
  output logic [31:0] inst_o,
  output logic [63:0] pc_o,
  output logic [4:0]  cause_o,
  output logic [63:0] tval_o,
  output logic        full_o
);

  logic        full_q;
  logic [31:0] inst_q;
  logic [63:0] pc_q;
  logic [4:0]  cause_q;
  logic [63:0] tval_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q  <= 1'b0;
      inst_q  <= INST_NOP;
      pc_q    <= '0;
      cause_q <= CAUSE_NONE;
      tval_q  <= '0;
    end else if (clear_i) begin
      full_q <= 1'b0;
    end else if (load_i) begin
      full_q  <= 1'b1;
      inst_q  <= inst_i;
      pc_q    <= pc_i;
      cause_q <= cause_i;
      tval_q  <= tval_i;
    end else if (pop_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o  = full_q;
  assign inst_o  = full_q ? inst_q  : INST_NOP;
  assign pc_o    = full_q ? pc_q    : 64'd0;
  assign cause_o = full_q ? cause_q : CAUSE_NONE;
  assign tval_o  = full_q ? tval_q  : 64'd0;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch PC owner: one outstanding 32-bit read at a time, redirects on trap/branch,
// drains responses belonging to squashed requests, halts on fetch exceptions.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        bj_en,
  input  logic [63:0] bj_target,
  input  logic        trap_en,
  input  logic [63:0] trap_target,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [63:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        rsp_err,
  output logic [31:0] inst_out,
  output logic [63:0] pc_out,
  output logic [4:0]  cause_out,
  output logic [63:0] tval_out
);

  fetch_state_e state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic [63:0]  req_addr_q, req_addr_d;
  logic         drain_pend_q, drain_pend_d;

  logic         redirect, accept, obuf_full, can_fill, ob_load;
  logic [31:0]  ld_inst;
  logic [63:0]  ld_pc, ld_tval;
  logic [4:0]   ld_cause;

  assign redirect  = trap_en | bj_en;
  assign req_valid = (state_q == ST_REQ);
  assign req_addr  = req_addr_q;
  assign accept    = req_valid & req_ready;
  // A new slot may be produced only if the buffer will be empty after this edge.
  assign can_fill  = ~obuf_full | ~stall;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    drain_pend_d = drain_pend_q;
    ob_load      = 1'b0;
    ld_inst      = INST_NOP;
    ld_pc        = pc_q;
    ld_cause     = CAUSE_NONE;
    ld_tval      = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (can_fill) begin
          if (pc_q[1:0] != 2'b00) begin
            ob_load  = 1'b1;
            ld_cause = CAUSE_INST_MISALIGNED;
            ld_tval  = pc_q;
            state_d  = ST_HALT;
          end else begin
            req_addr_d = pc_q;
            state_d    = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (req_ready) begin
          state_d      = drain_pend_q ? ST_DRAIN : ST_WAIT;
          drain_pend_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (rsp_valid) begin
          ob_load = 1'b1;
          if (rsp_err) begin
            ld_cause = CAUSE_INST_ACCESS_FAULT;
            ld_tval  = pc_q;
            state_d  = ST_HALT;
          end else begin
            ld_inst = rsp_data;
            pc_d    = pc_q + 64'd4;
            state_d = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        if (rsp_valid) state_d = ST_IDLE;
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase

    // An unaccepted request must be held as-is; the new target waits in pc_q.
    if (redirect) begin
      pc_d       = trap_en ? trap_target : bj_target;
      req_addr_d = req_addr_q;
      ob_load    = 1'b0;
      unique case (state_q)
        ST_REQ: begin
          state_d      = accept ? ST_DRAIN : ST_REQ;
          drain_pend_d = ~accept;
        end
        ST_WAIT, ST_DRAIN: state_d = rsp_valid ? ST_IDLE : ST_DRAIN;
        default:           state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      drain_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      drain_pend_q <= drain_pend_d;
    end
  end

  fetch_obuf u_obuf (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ob_load),
    .pop_i   (~stall),
    .clear_i (redirect),
    .inst_i  (ld_inst),
    .pc_i    (ld_pc),
    .cause_i (ld_cause),
    .tval_i  (ld_tval),
    .inst_o  (inst_out),
    .pc_o    (pc_out),
    .cause_o (cause_out),
    .tval_o  (tval_out),
    .full_o  (obuf_full)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed vector table plus randomized run against a transaction-level scoreboard.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam logic [63:0] RST_PC = 64'h1000;
  localparam logic [63:0] TOP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, bj_en = 1'b0, trap_en = 1'b0;
  logic        req_ready = 1'b0, rsp_valid = 1'b0, rsp_err = 1'b0;
  logic [63:0] bj_target = '0, trap_target = '0;
  logic [31:0] rsp_data = '0;
  logic        req_valid;
  logic [63:0] req_addr, pc_out, tval_out;
  logic [31:0] inst_out;
  logic [4:0]  cause_out;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .bj_en(bj_en), .bj_target(bj_target), .trap_en(trap_en), .trap_target(trap_target),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .inst_out(inst_out), .pc_out(pc_out), .cause_out(cause_out), .tval_out(tval_out)
  );

  typedef struct {
    logic        st, rdy, rv, err, bj, tr;
    logic [31:0] dat;
    logic [63:0] tbj, ttr;
    logic        e_rv;
    logic [63:0] e_addr;
    slot_t       e_slot;
  } vec_t;

  localparam slot_t EMPTY = '{inst: INST_NOP, pc: 64'd0, cause: CAUSE_NONE, tval: 64'd0};

  vec_t  vt[$];
  slot_t exq[$];

  function automatic vec_t vs(logic st, logic rdy, logic rv, logic err, logic [31:0] dat,
                              logic bj, logic tr, logic [63:0] tbj, logic [63:0] ttr,
                              logic erv, logic [63:0] eaddr, slot_t es);
    vec_t v;
    v.st = st; v.rdy = rdy; v.rv = rv; v.err = err; v.dat = dat;
    v.bj = bj; v.tr = tr; v.tbj = tbj; v.ttr = ttr;
    v.e_rv = erv; v.e_addr = eaddr; v.e_slot = es;
    return v;
  endfunction

  function automatic slot_t mk(logic [31:0] i, logic [63:0] p, logic [4:0] c, logic [63:0] t);
    slot_t s;
    s.inst = i; s.pc = p; s.cause = c; s.tval = t;
    return s;
  endfunction

  function automatic logic [31:0] memf(logic [63:0] a);
    return (a[31:0] ^ a[63:32] ^ 32'h5A5A_0000) | 32'h8000_0000;
  endfunction

  function automatic slot_t cur_slot();
    return mk(inst_out, pc_out, cause_out, tval_out);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic chk_slot(input string name, input slot_t act, input slot_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got inst=%h pc=%h cause=%0d tval=%h, want inst=%h pc=%h cause=%0d tval=%h",
               name, act.inst, act.pc, act.cause, act.tval, exp.inst, exp.pc, exp.cause, exp.tval);
    end
  endtask

  // random-phase model state
  logic [63:0] exp_pc, o_addr, prev_addr, tgt;
  logic        halted, outst, taint, prev_stuck, red, rsp_real;
  int          dly, n_cons;

  initial begin
    slot_t s1, s_ill, s_flt, s_wrap;
    s1     = mk(32'h0010_0093, 64'h1000, CAUSE_NONE, 64'd0);
    s_flt  = mk(INST_NOP, 64'h3000, CAUSE_INST_ACCESS_FAULT, 64'h3000);
    s_ill  = mk(INST_NOP, 64'h2002, CAUSE_INST_MISALIGNED, 64'h2002);
    s_wrap = mk(32'h0000_0513, TOP_PC, CAUSE_NONE, 64'd0);

    //            st rdy rv err data          bj tr tbj       ttr     erv addr     slot
    vt.push_back(vs(0, 1, 0, 0, 32'h0,        0, 0, 64'h0,    64'h0,  0, 64'h1000, EMPTY));
    vt.push_back(vs(0, 1, 0, 0, 32'h0,        0, 0, 64'h0,    64'h0,  1, 64'h1000, EMPTY));
    vt.push_back(vs(0, 1, 1, 0, 32'h0010_0093,0, 0, 64'h0,    64'h0,  0, 64'h0,    EMPTY));
    for (int k = 0; k < 5; k++)
      vt.push_back(vs(1, 1, 0, 0, 32'h0,      0, 0, 64'h0,    64'h0,  0, 64'h0,    s1));
    vt.push_back(vs(0, 1, 0, 0, 32'h0,        0, 0, 64'h0,    64'h0,  0, 64'h0,    s1));
    vt.push_back(vs(0, 0, 0, 0, 32'h0,        0, 0, 64'h0,    64'h0,  1, 64'h1004, EMPTY));
    vt.push_back(vs(0, 1, 0, 0, 32'h0,        0, 0, 64'h0,    64'h0,  1, 64'h1004, EMPTY));
    vt.push_back(vs(0, 1, 0, 0, 32'h0,        1, 0, 64'h2000, 64'h0,  0, 64'h0,    EMPTY));
    vt.push_back(vs(0, 1, 1, 0, 32'hDEADBEEF, 0, 0, 64'h0,    64'h0,  0, 64'h0,    EMPTY));
    vt.push_back(vs(0, 1, 0, 0, 32'h0,        0, 0, 64'h0,    64'h0,  0, 64'h0,    EMPTY));
    vt.push_back(vs(0, 1, 0, 0, 32'h0,        1, 1, 64'h2000, 64'h3000, 1, 64'h2000, EMPTY));
    vt.push_back(vs(0, 1, 1, 0, 32'hCAFEF00D, 0, 0, 64'h0,    64'h0,  0, 64'h0,    EMPTY));
    vt.push_back(vs(0, 1, 0, 0, 32'h0,        0, 0, 64'h0,    64'h0,  0, 64'h0,    EMPTY));
    vt.push_back(vs(0, 1, 0, 0, 32'h0,        0, 0, 64'h0,    64'h0,  1, 64'h3000, EMPTY));
    vt.push_back(vs(0, 1, 1, 1, 32'h1111_1111,0, 0, 64'h0,    64'h0,  0, 64'h0,    EMPTY));
    vt.push_back(vs(0, 1, 0, 0, 32'h0,        0, 0, 64'h0,    64'h0,  0, 64'h0,    s_flt));
    vt.push_back(vs(0, 1, 0, 0, 32'h0,        1, 0, 64'h2002, 64'h0,  0, 64'h0,    EMPTY));
    vt.push_back(vs(0, 1, 0, 0, 32'h0,        0, 0, 64'h0,    64'h0,  0, 64'h0,    EMPTY));
    vt.push_back(vs(1, 1, 0, 0, 32'h0,        0, 0, 64'h0,    64'h0,  0, 64'h0,    s_ill));
    vt.push_back(vs(0, 1, 0, 0, 32'h0,        0, 0, 64'h0,    64'h0,  0, 64'h0,    s_ill));
    vt.push_back(vs(0, 1, 0, 0, 32'h0,        0, 0, 64'h0,    64'h0,  0, 64'h0,    EMPTY));
    vt.push_back(vs(0, 1, 0, 0, 32'h0,        0, 1, 64'h0,    TOP_PC, 0, 64'h0,    EMPTY));
    vt.push_back(vs(0, 1, 0, 0, 32'h0,        0, 0, 64'h0,    64'h0,  0, 64'h0,    EMPTY));
    vt.push_back(vs(0, 1, 0, 0, 32'h0,        0, 0, 64'h0,    64'h0,  1, TOP_PC,   EMPTY));
    vt.push_back(vs(0, 1, 1, 0, 32'h0000_0513,0, 0, 64'h0,    64'h0,  0, 64'h0,    EMPTY));
    vt.push_back(vs(0, 1, 0, 0, 32'h0,        0, 0, 64'h0,    64'h0,  0, 64'h0,    s_wrap));
    vt.push_back(vs(0, 0, 0, 0, 32'h0,        1, 0, 64'h4000, 64'h0,  1, 64'h0,    EMPTY));
    vt.push_back(vs(0, 1, 0, 0, 32'h0,        0, 0, 64'h0,    64'h0,  1, 64'h0,    EMPTY));
    vt.push_back(vs(0, 1, 1, 0, 32'h1234_5678,0, 0, 64'h0,    64'h0,  0, 64'h0,    EMPTY));
    vt.push_back(vs(0, 1, 0, 0, 32'h0,        0, 0, 64'h0,    64'h0,  0, 64'h0,    EMPTY));
    vt.push_back(vs(0, 1, 0, 0, 32'h0,        0, 0, 64'h0,    64'h0,  1, 64'h4000, EMPTY));
    vt.push_back(vs(0, 1, 1, 0, 32'h0BAD_F00D,1, 0, 64'h5000, 64'h0,  0, 64'h0,    EMPTY));
    vt.push_back(vs(0, 1, 0, 0, 32'h0,        0, 0, 64'h0,    64'h0,  0, 64'h0,    EMPTY));
    vt.push_back(vs(0, 1, 0, 0, 32'h0,        0, 0, 64'h0,    64'h0,  1, 64'h5000, EMPTY));

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < vt.size(); i++) begin
      stall = vt[i].st; req_ready = vt[i].rdy; rsp_valid = vt[i].rv; rsp_err = vt[i].err;
      rsp_data = vt[i].dat; bj_en = vt[i].bj; trap_en = vt[i].tr;
      bj_target = vt[i].tbj; trap_target = vt[i].ttr;
      #1;
      chk($sformatf("vec%0d_req_valid", i), 64'(req_valid), 64'(vt[i].e_rv));
      if (vt[i].e_rv || i == 0) chk($sformatf("vec%0d_req_addr", i), req_addr, vt[i].e_addr);
      chk_slot($sformatf("vec%0d_slot", i), cur_slot(), vt[i].e_slot);
      @(negedge clk);
    end

    // Reset while a request is outstanding; stray responses afterwards are ignored.
    bj_en = 1'b0; trap_en = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h7777_7777; req_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_req_valid", 64'(req_valid), 64'd0);
    chk("midrst_req_addr", req_addr, RST_PC);
    chk_slot("midrst_slot", cur_slot(), EMPTY);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("postrst_req_valid", 64'(req_valid), 64'd1);
    chk("postrst_req_addr", req_addr, RST_PC);
    chk_slot("postrst_stray_ignored", cur_slot(), EMPTY);
    @(negedge clk);
    chk_slot("postrst_still_empty", cur_slot(), EMPTY);
    req_ready = 1'b1; rsp_valid = 1'b0;
    @(negedge clk);
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h0020_0113;
    @(negedge clk);
    rsp_valid = 1'b0;
    #1;
    chk_slot("postrst_first_inst", cur_slot(), mk(32'h0020_0113, RST_PC, CAUSE_NONE, 64'd0));

    // Randomized run.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_pc = RST_PC; halted = 1'b0; outst = 1'b0; taint = 1'b0; prev_stuck = 1'b0;
    prev_addr = '0; o_addr = '0; dly = 0; n_cons = 0; exq.delete();
    for (int c = 0; c < 4000; c++) begin
      stall     = ($urandom_range(0, 3) == 0);
      req_ready = ($urandom_range(0, 2) != 0);
      red       = halted ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 30) == 0);
      bj_en = 1'b0; trap_en = 1'b0;
      bj_target = {$urandom, $urandom}; trap_target = {$urandom, $urandom};
      tgt = '0;
      if (red) begin
        tgt = {$urandom, $urandom};
        if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
        if ($urandom_range(0, 9) == 0) tgt = TOP_PC;
        case ($urandom_range(0, 2))
          0:       begin bj_en = 1'b1; bj_target = tgt; end
          1:       begin trap_en = 1'b1; trap_target = tgt; end
          default: begin bj_en = 1'b1; trap_en = 1'b1; trap_target = tgt; end
        endcase
      end
      rsp_valid = 1'b0; rsp_err = 1'b0; rsp_data = $urandom; rsp_real = 1'b0;
      if (outst) begin
        if (dly == 0) begin
          rsp_valid = 1'b1; rsp_real = 1'b1; rsp_data = memf(o_addr);
          rsp_err = ($urandom_range(0, 15) == 0);
        end else dly--;
      end else if ($urandom_range(0, 15) == 0) begin
        rsp_valid = 1'b1; rsp_err = $urandom_range(0, 1);
      end
      #1;

      if (prev_stuck) begin
        chk("rand_req_hold_valid", 64'(req_valid), 64'd1);
        chk("rand_req_hold_addr", req_addr, prev_addr);
      end
      if (req_valid) chk("rand_one_outstanding", 64'(outst), 64'd0);
      if (halted && !taint) chk("rand_halt_no_req", 64'(req_valid), 64'd0);
      if (!stall && cur_slot() !== EMPTY) begin
        n_cons++;
        if (exq.size() == 0) chk_slot("rand_slot_unexpected", cur_slot(), EMPTY);
        else chk_slot("rand_slot", cur_slot(), exq.pop_front());
      end
      if (rsp_real) begin
        if (!taint && !red) begin
          if (rsp_err) begin
            exq.push_back(mk(INST_NOP, o_addr, CAUSE_INST_ACCESS_FAULT, o_addr));
            halted = 1'b1;
          end else begin
            exq.push_back(mk(memf(o_addr), o_addr, CAUSE_NONE, 64'd0));
            exp_pc = o_addr + 64'd4;
          end
        end
        outst = 1'b0; taint = 1'b0;
      end
      if (req_valid && req_ready) begin
        if (!taint) chk("rand_req_addr", req_addr, exp_pc);
        outst = 1'b1; o_addr = req_addr; dly = $urandom_range(0, 2);
      end
      if (red) begin
        exq.delete();
        exp_pc = tgt;
        halted = (tgt[1:0] != 2'b00);
        if (halted) exq.push_back(mk(INST_NOP, tgt, CAUSE_INST_MISALIGNED, tgt));
        taint = req_valid || outst;
      end
      prev_stuck = req_valid && !req_ready;
      prev_addr  = req_addr;
      @(negedge clk);
    end
    chk("rand_progress", 64'(n_cons > 150), 64'd1);
    chk("rand_backlog", 64'(exq.size() <= 1), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
